// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe
//
// Handshaked EX-stage ALU. It sits between the operand muxes and the EX/MEM
// register. Simple operations produce a registered result one edge after
// they are accepted. MUL, DIVU and REMU are iterative (one bit per edge) and
// stall the pipeline through in_ready/out_valid while they run.
//
// Parameters
//   WIDTH    operand/result width (power of two, >= 8)
//   SHW      shift-amount width, derived from WIDTH
//   ITER_EN  1 = MUL/DIVU/REMU implemented, 0 = those opcodes are reserved
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands/opcode valid
//   in_ready   block can accept an operation this cycle
//   a, b       operands (low SHW bits of b = shift amount)
//   aluc       4-bit opcode
//   out_valid  r and flags valid
//   out_ready  consumer takes the result this cycle
//   r          result
//   zero       r == 0
//   ovf        signed overflow (ADD/SUB only)
//   dbz        divide by zero (DIVU/REMU with b == 0)
// ---------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHW     = $clog2(WIDTH),
    parameter int ITER_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             zero,
    output logic             ovf,
    output logic             dbz
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_LUI  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_MUL  = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1101;
    localparam logic [3:0] OP_REMU = 4'b1110;

    localparam bit HAS_ITER = (ITER_EN != 0);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [SHW-1:0]   cnt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] d_q;

    logic             accept;
    logic             go_iter;
    logic             last_step;
    logic             busy;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;
    logic [WIDTH-1:0] simple_r;
    logic             simple_ovf;
    logic             simple_dbz;

    logic [3:0]       src_op;
    logic [WIDTH-1:0] src_p;
    logic [WIDTH-1:0] src_s;
    logic [WIDTH-1:0] src_d;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_dif;
    logic             q_bit;
    logic [WIDTH-1:0] step_p;
    logic [WIDTH-1:0] step_s;
    logic [WIDTH-1:0] step_d;
    logic [WIDTH-1:0] iter_r;

    assign accept    = in_valid && in_ready;
    assign busy      = (state == BUSY);
    // The counter holds the steps still to run; the edge performing the
    // final step (counter at 1) is the one that moves to DONE.
    assign last_step = busy && (cnt == SHW'(1));
    assign shamt     = b[SHW-1:0];
    assign sum       = a + b;
    assign dif       = a - b;

    // A division by zero short-circuits to the one-edge path.
    assign go_iter = HAS_ITER &&
                     ((aluc == OP_MUL) ||
                      (((aluc == OP_DIVU) || (aluc == OP_REMU)) && (b != '0)));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = go_iter ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        state_nxt = go_iter ? BUSY : DONE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs; DONE accepts a new op only when the held result
    // leaves on the same edge.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    // Single-edge result. It also covers the DIVU/REMU by-zero cases and the
    // reserved opcodes.
    always_comb begin
        simple_r   = '0;
        simple_ovf = 1'b0;
        simple_dbz = 1'b0;
        case (aluc)
            OP_ADD: begin
                simple_r   = sum;
                simple_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  simple_r = a & b;
            OP_XOR:  simple_r = a ^ b;
            OP_OR:   simple_r = a | b;
            OP_SLT:  simple_r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  simple_r = a << shamt;
            OP_SRL:  simple_r = a >> shamt;
            OP_SUB: begin
                simple_r   = dif;
                simple_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_LUI:  simple_r = b << (WIDTH / 2);
            OP_SRA:  simple_r = $signed(a) >>> shamt;
            OP_SLTU: simple_r = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_NOR:  simple_r = ~(a | b);
            OP_DIVU: begin
                if (HAS_ITER && (b == '0)) begin
                    simple_r   = '1;
                    simple_dbz = 1'b1;
                end
            end
            OP_REMU: begin
                if (HAS_ITER && (b == '0)) begin
                    simple_r   = a;
                    simple_dbz = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // One iteration step. On the accepting edge it works straight from the
    // ports, so the first bit is done while the operands are captured. In BUSY
    // it works from the working registers.
    //   MUL : p = partial product, s = multiplicand (<<), d = multiplier (>>)
    //   DIV : p = partial remainder, s = dividend shifting into quotient,
    //         d = divisor
    always_comb begin
        src_op  = busy ? op_q : aluc;
        src_p   = busy ? p_q  : '0;
        src_s   = busy ? s_q  : a;
        src_d   = busy ? d_q  : b;
        rem_sh  = {src_p, src_s[WIDTH-1]};
        rem_dif = rem_sh - {1'b0, src_d};
        q_bit   = 1'b0;
        step_p  = src_p;
        step_s  = src_s;
        step_d  = src_d;
        if (src_op == OP_MUL) begin
            step_p = src_p + (src_d[0] ? src_s : '0);
            step_s = src_s << 1;
            step_d = src_d >> 1;
        end else begin
            // Restoring division: keep the trial subtraction only if it did
            // not borrow.
            q_bit  = ~rem_dif[WIDTH];
            step_p = q_bit ? rem_dif[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            step_s = {src_s[WIDTH-2:0], q_bit};
        end
    end

    always_comb begin
        iter_r = step_p;
        if (op_q == OP_DIVU) begin
            iter_r = step_s;
        end
    end

    // Operand capture, iteration registers and the result/flag registers.
    // r and the flags only change when a new result is produced, so they
    // stay stable while a result waits for out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            op_q <= '0;
            p_q  <= '0;
            s_q  <= '0;
            d_q  <= '0;
            r    <= '0;
            zero <= 1'b0;
            ovf  <= 1'b0;
            dbz  <= 1'b0;
        end else if (accept) begin
            op_q <= aluc;
            if (go_iter) begin
                cnt <= SHW'(WIDTH - 1);
                p_q <= step_p;
                s_q <= step_s;
                d_q <= step_d;
            end else begin
                r    <= simple_r;
                zero <= (simple_r == '0);
                ovf  <= simple_ovf;
                dbz  <= simple_dbz;
            end
        end else if (busy) begin
            cnt <= cnt - SHW'(1);
            p_q <= step_p;
            s_q <= step_s;
            d_q <= step_d;
            if (last_step) begin
                r    <= iter_r;
                zero <= (iter_r == '0);
                ovf  <= 1'b0;
                dbz  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe
//
// Self-checking bench for alu_pipe (WIDTH = 32, ITER_EN = 1). Every accepted
// operation pushes its expected result onto a scoreboard. A monitor pops and
// compares the result when the DUT transfers it, and also checks the
// accept-to-out_valid latency.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

    localparam int W = 32;

    localparam logic [3:0] ADD  = 4'h0;
    localparam logic [3:0] AND_ = 4'h1;
    localparam logic [3:0] XOR_ = 4'h2;
    localparam logic [3:0] OR_  = 4'h3;
    localparam logic [3:0] SLT  = 4'h4;
    localparam logic [3:0] SLL  = 4'h5;
    localparam logic [3:0] SRL  = 4'h6;
    localparam logic [3:0] SUB  = 4'h7;
    localparam logic [3:0] LUI  = 4'h8;
    localparam logic [3:0] SRA  = 4'h9;
    localparam logic [3:0] SLTU = 4'hA;
    localparam logic [3:0] NOR_ = 4'hB;
    localparam logic [3:0] MUL  = 4'hC;
    localparam logic [3:0] DIVU = 4'hD;
    localparam logic [3:0] REMU = 4'hE;
    localparam logic [3:0] RSVD = 4'hF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   aluc = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] r;
    logic         zero;
    logic         ovf;
    logic         dbz;

    alu_pipe #(.WIDTH(W), .ITER_EN(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .aluc      (aluc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .zero      (zero),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic         zero;
        logic         ovf;
        logic         dbz;
        int           lat;
    } exp_t;

    typedef struct {
        logic [3:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        exp_t       e;
    } vec_t;

    typedef struct {
        logic [3:0] op;
        exp_t       e;
        int         acc_cyc;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    sb_t  popped;
    int   n_vec = 0;
    int   n_miss = 0;
    int   cyc = 0;
    int   n_xfer = 0;
    bit   head_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic addVec(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] er, input logic ez, input logic eo,
                          input logic ed, input int lat);
        vec_t v;
        v.op     = op;
        v.a      = x;
        v.b      = y;
        v.e.r    = er;
        v.e.zero = ez;
        v.e.ovf  = eo;
        v.e.dbz  = ed;
        v.e.lat  = lat;
        vecs.push_back(v);
    endtask

    // Reference for the simple opcodes, using wide signed arithmetic
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t   e;
        longint sx;
        longint sy;
        longint t;
        longint sh;
        e.r   = '0;
        e.ovf = 1'b0;
        e.dbz = 1'b0;
        e.lat = 1;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (op)
            ADD: begin
                t = sx + sy;
                e.r = t[W-1:0];
                e.ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            SUB: begin
                t = sx - sy;
                e.r = t[W-1:0];
                e.ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            AND_: e.r = x & y;
            XOR_: e.r = x ^ y;
            OR_:  e.r = x | y;
            NOR_: e.r = ~(x | y);
            SLT:  e.r = (sx < sy) ? 32'd1 : 32'd0;
            SLTU: e.r = (x < y) ? 32'd1 : 32'd0;
            SLL:  e.r = x << y[4:0];
            SRL:  e.r = x >> y[4:0];
            SRA: begin
                sh = sx >>> y[4:0];
                e.r = sh[W-1:0];
            end
            LUI:  e.r = {y[15:0], 16'h0000};
            default: e.r = '0;
        endcase
        e.zero = (e.r == '0);
        return e;
    endfunction

    // Drive an operation and hold it until accepted, pushing its expectation
    // onto the scoreboard at the accepting edge. Returns after that edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input exp_t e, output int waited);
        sb_t s;
        bit  done;
        in_valid = 1'b1;
        aluc     = op;
        a        = x;
        b        = y;
        waited   = 0;
        done     = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            waited++;
            if (in_ready) begin
                s.op      = op;
                s.e       = e;
                s.acc_cyc = cyc;
                sb.push_back(s);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) checkOutput("accept timeout in_ready", in_ready, 1);
    endtask

    // Drop in_valid and scramble the operand buses to show operands were captured.
    task automatic idle();
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        aluc     = 4'($urandom);
    endtask

    task automatic waitDrain();
        for (int k = 0; k < 100 && sb.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            checkOutput("drain timeout pending results", sb.size(), 0);
            sb.delete();
        end
    endtask

    // Scoreboard monitor: compares at the negedge before the transfer edge
    always @(negedge clk) begin
        if (!rst_n) begin
            head_seen = 1'b0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                checkOutput("out_valid with empty scoreboard", out_valid, 0);
            end else begin
                if (!head_seen) begin
                    head_seen = 1'b1;
                    if (sb[0].e.lat != 0)
                        checkOutput($sformatf("latency op%0h", sb[0].op), cyc - sb[0].acc_cyc, sb[0].e.lat);
                end
                if (out_ready) begin
                    popped = sb.pop_front();
                    head_seen = 1'b0;
                    n_xfer++;
                    checkOutput($sformatf("r op%0h", popped.op), r, popped.e.r);
                    checkOutput($sformatf("zero/ovf/dbz op%0h", popped.op), {zero, ovf, dbz},
                                {popped.e.zero, popped.e.ovf, popped.e.dbz});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        n_miss++;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        int   w;
        int   wsum;
        int   x0;
        exp_t e;
        logic [3:0] simple_ops[12];

        simple_ops = '{ADD, AND_, XOR_, OR_, SLT, SLL, SRL, SUB, LUI, SRA, SLTU, NOR_};

        //      op    a             b             r             z     o     d     lat
        addVec(ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1);
        addVec(SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 1);
        addVec(SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1);
        addVec(SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1);
        addVec(SRA,  32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1'b0, 1'b0, 1);
        addVec(SRL,  32'h80000000, 32'h00000024, 32'h08000000, 1'b0, 1'b0, 1'b0, 1);
        addVec(LUI,  32'h0000DEAD, 32'h00001234, 32'h12340000, 1'b0, 1'b0, 1'b0, 1);
        addVec(SLL,  32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1'b0, 1'b0, 1);
        addVec(AND_, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b0, 1);
        addVec(OR_,  32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0, 1'b0, 1'b0, 1);
        addVec(NOR_, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1);
        addVec(XOR_, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1);
        addVec(SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1);
        addVec(SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1);
        addVec(ADD,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 1);
        addVec(RSVD, 32'h00000005, 32'h00000006, 32'h00000000, 1'b1, 1'b0, 1'b0, 1);
        addVec(MUL,  32'h00010000, 32'h00010001, 32'h00010000, 1'b0, 1'b0, 1'b0, 32);
        addVec(MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32);
        addVec(MUL,  32'h00000003, 32'h00000005, 32'h0000000F, 1'b0, 1'b0, 1'b0, 32);
        addVec(MUL,  32'h12345678, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 0);
        addVec(DIVU, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0, 1'b0, 32);
        addVec(REMU, 32'd100,      32'd7,        32'd2,        1'b0, 1'b0, 1'b0, 32);
        addVec(DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 1'b0, 1'b0, 1'b0, 32);
        addVec(REMU, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 1'b0, 1'b0, 1'b0, 32);
        addVec(DIVU, 32'd5,        32'd7,        32'd0,        1'b1, 1'b0, 1'b0, 32);
        addVec(REMU, 32'd5,        32'd7,        32'd5,        1'b0, 1'b0, 1'b0, 32);
        addVec(DIVU, 32'd9,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1);
        addVec(REMU, 32'd9,        32'd0,        32'd9,        1'b0, 1'b0, 1'b1, 1);

        // Reset state
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset in_ready", in_ready, 1);
        checkOutput("reset r", r, 0);
        checkOutput("reset flags", {zero, ovf, dbz}, 3'b000);
        @(posedge clk);
        #1;

        // Table vectors, one at a time
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e, w);
            idle();
            waitDrain();
        end

        // MUL: handshake stays low for the whole BUSY window, and in_valid
        // raised during BUSY is ignored.
        applyStimulus(MUL, 32'h00010000, 32'h00010001, '{32'h00010000, 1'b0, 1'b0, 1'b0, 32}, w);
        idle();
        for (int i = 0; i < 31; i++) begin
            if (i < 20) begin
                in_valid = 1'b1;
                aluc     = ADD;
                a        = 32'd1;
                b        = 32'd1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            checkOutput($sformatf("busy in_ready/out_valid cycle %0d", i), {in_ready, out_valid}, 2'b00);
            @(posedge clk);
            #1;
        end
        idle();
        waitDrain();

        // Backpressure: XOR result held for 5 cycles, then released with a
        // same-edge accept.
        out_ready = 1'b0;
        applyStimulus(XOR_, 32'h12345678, 32'h0F0F0F0F, '{32'h1D3B5977, 1'b0, 1'b0, 1'b0, 1}, w);
        idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("held r cycle %0d", i), r, 32'h1D3B5977);
            checkOutput($sformatf("held valid/ready/flags cycle %0d", i),
                        {out_valid, in_ready, zero, ovf, dbz}, 5'b10000);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        applyStimulus(ADD, 32'd1, 32'd2, '{32'd3, 1'b0, 1'b0, 1'b0, 1}, w);
        checkOutput("same-edge transfer+accept wait", w, 1);
        idle();
        waitDrain();

        // Back-to-back: 8 simple ops with in_valid and out_ready held high
        x0   = n_xfer;
        wsum = 0;
        for (int i = 0; i < 8; i++) begin
            logic [3:0]   op;
            logic [W-1:0] x;
            logic [W-1:0] y;
            op = simple_ops[$urandom_range(0, 11)];
            x  = $urandom;
            y  = $urandom;
            e  = model(op, x, y);
            applyStimulus(op, x, y, e, w);
            wsum += w;
        end
        idle();
        waitDrain();
        checkOutput("back-to-back accept cycles", wsum, 8);
        checkOutput("back-to-back results", n_xfer - x0, 8);

        // Reset in the middle of a MUL, with a nonzero result still held in r
        applyStimulus(DIVU, 32'd100, 32'd7, '{32'd14, 1'b0, 1'b0, 1'b0, 32}, w);
        idle();
        waitDrain();
        applyStimulus(MUL, 32'h00000007, 32'h00000009, '{32'd63, 1'b0, 1'b0, 1'b0, 32}, w);
        idle();
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset out_valid", out_valid, 0);
        checkOutput("async reset r", r, 0);
        checkOutput("async reset flags", {zero, ovf, dbz}, 3'b000);
        sb.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post-reset in_ready", in_ready, 1);
        checkOutput("post-reset out_valid", out_valid, 0);
        repeat (40) @(posedge clk);
        #1;
        applyStimulus(ADD, 32'h0000FFFF, 32'h00000001, '{32'h00010000, 1'b0, 1'b0, 1'b0, 1}, w);
        idle();
        waitDrain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
